// File: rtl/cby_param_cfg_frame.sv
// Parametrised Y-channel connection block: channel pass-through plus per-pin muxes
// whose selects live in shadow/active register banks loaded through a valid/ready port.
module cby_param_cfg_frame #(
  parameter int CHAN_W   = 9,
  parameter int N_IPIN   = 10,
  parameter int MUX_SIZE = 6,
  parameter int STRIDE   = 4,
  parameter int SEL_W    = $clog2(MUX_SIZE),
  parameter int ADDR_W   = $clog2(N_IPIN)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chany_top_in,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [N_IPIN-1:0] ipin_out,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_rvalid,
  output logic [SEL_W-1:0]  cfg_rdata,
  output logic              cfg_err,
  output logic              cfg_done,
  output logic              active_valid
);

  localparam int MUX_PAD = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [SEL_W-1:0]   shadow_r [N_IPIN];
  logic [SEL_W-1:0]   active_r [N_IPIN];
  logic               active_valid_r;
  logic               rvalid_r;
  logic               err_r;
  logic [SEL_W-1:0]   rdata_r;
  logic               accept_s;
  logic               addr_ok_s;
  logic               wdata_ok_s;
  logic [MUX_PAD-1:0] mux_in_s [N_IPIN];
  logic [N_IPIN-1:0]  ipin_s;

  assign accept_s   = cfg_valid & (state_r == ST_IDLE);
  assign addr_ok_s  = (int'(cfg_addr) < N_IPIN);
  assign wdata_ok_s = (int'(cfg_wdata) < MUX_SIZE);

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  assign cfg_ready    = (state_r == ST_IDLE);
  assign cfg_done     = (state_r == ST_DONE);
  assign cfg_rvalid   = rvalid_r;
  assign cfg_rdata    = rdata_r;
  assign cfg_err      = err_r;
  assign active_valid = active_valid_r;

  // Commit sequencer next-state: a commit is only taken from IDLE, never queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMMIT: state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, configuration banks and response registers.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r        <= ST_IDLE;
      active_valid_r <= 1'b0;
      rvalid_r       <= 1'b0;
      err_r          <= 1'b0;
      rdata_r        <= '0;
      for (int p = 0; p < N_IPIN; p++) begin
        shadow_r[p] <= '0;
        active_r[p] <= '0;
      end
    end else begin
      state_r  <= state_s;
      rvalid_r <= accept_s & ~cfg_we;
      // Rejected requests are still consumed; only the error pulse marks them.
      err_r    <= accept_s & ~(addr_ok_s & (~cfg_we | wdata_ok_s));
      if (accept_s & cfg_we & addr_ok_s & wdata_ok_s) begin
        shadow_r[cfg_addr] <= cfg_wdata;
      end
      if (accept_s & ~cfg_we) begin
        rdata_r <= addr_ok_s ? shadow_r[cfg_addr] : '0;
      end
      if (state_r == ST_COMMIT) begin
        for (int p = 0; p < N_IPIN; p++) begin
          active_r[p] <= shadow_r[p];
        end
        active_valid_r <= 1'b1;
      end
    end
  end

  // Mux input k of pin p taps track (p + (k/2)*STRIDE) mod CHAN_W; even k from below, odd from above.
  always_comb begin
    for (int p = 0; p < N_IPIN; p++) begin
      mux_in_s[p] = '0;
      for (int k = 0; k < MUX_SIZE; k++) begin
        mux_in_s[p][k] = ((k % 2) == 1) ? chany_top_in[(p + (k / 2) * STRIDE) % CHAN_W]
                                        : chany_bottom_in[(p + (k / 2) * STRIDE) % CHAN_W];
      end
      ipin_s[p] = mux_in_s[p][active_r[p]];
    end
  end

  assign ipin_out = active_valid_r ? ipin_s : {N_IPIN{1'b0}};

endmodule

// File: tb/tb_cby_param_cfg_frame.sv
// Directed bench for cby_param_cfg_frame: pass-through and config-port tables,
// then hand sequences for commit timing, same-cycle write+commit and reset mid-commit.
module tb_cby_param_cfg_frame;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic [8:0] chany_bottom_in, chany_top_in, chany_bottom_out, chany_top_out;
  logic [9:0] ipin_out;
  logic       cfg_valid, cfg_ready, cfg_we, cfg_commit;
  logic [3:0] cfg_addr;
  logic [2:0] cfg_wdata, cfg_rdata;
  logic       cfg_rvalid, cfg_err, cfg_done, active_valid;

  int total = 0;
  int bad   = 0;
  logic [2:0] sel_m [10];

  cby_param_cfg_frame dut (
    .prog_clk(prog_clk), .pReset(pReset),
    .chany_bottom_in(chany_bottom_in), .chany_top_in(chany_top_in),
    .chany_bottom_out(chany_bottom_out), .chany_top_out(chany_top_out),
    .ipin_out(ipin_out),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .cfg_done(cfg_done), .active_valid(active_valid)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [8:0] bot;
    logic [8:0] top;
    logic [8:0] exp_top_out;
    logic [8:0] exp_bot_out;
  } pt_vec_t;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [2:0] wdata;
    logic       exp_rv;
    logic [2:0] exp_rd;
    logic       exp_err;
  } cfg_vec_t;

  pt_vec_t  pt [4];
  cfg_vec_t cv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Expected pins from the track formula with the bench's own copy of the selects.
  function automatic logic [9:0] model_ipin();
    logic [9:0] r;
    int t;
    r = '0;
    for (int p = 0; p < 10; p++) begin
      t = (p + (int'(sel_m[p]) / 2) * 4) % 9;
      r[p] = sel_m[p][0] ? chany_top_in[t] : chany_bottom_in[t];
    end
    return r;
  endfunction

  initial begin
    pt[0] = '{9'h155, 9'h0AA, 9'h155, 9'h0AA};
    pt[1] = '{9'h000, 9'h1FF, 9'h000, 9'h1FF};
    pt[2] = '{9'h123, 9'h0F0, 9'h123, 9'h0F0};
    pt[3] = '{9'h1FF, 9'h001, 9'h1FF, 9'h001};

    cv[0]  = '{1'b1, 4'd2,  3'd3, 1'b0, 3'd0, 1'b0};
    cv[1]  = '{1'b0, 4'd2,  3'd0, 1'b1, 3'd3, 1'b0};
    cv[2]  = '{1'b1, 4'd12, 3'd1, 1'b0, 3'd3, 1'b1};
    cv[3]  = '{1'b1, 4'd0,  3'd7, 1'b0, 3'd3, 1'b1};
    cv[4]  = '{1'b0, 4'd0,  3'd0, 1'b1, 3'd0, 1'b0};
    cv[5]  = '{1'b0, 4'd12, 3'd0, 1'b1, 3'd0, 1'b1};
    cv[6]  = '{1'b1, 4'd5,  3'd6, 1'b0, 3'd0, 1'b1};
    cv[7]  = '{1'b1, 4'd5,  3'd5, 1'b0, 3'd0, 1'b0};
    cv[8]  = '{1'b0, 4'd5,  3'd0, 1'b1, 3'd5, 1'b0};
    cv[9]  = '{1'b0, 4'd10, 3'd0, 1'b1, 3'd0, 1'b1};
    cv[10] = '{1'b0, 4'd9,  3'd0, 1'b1, 3'd0, 1'b0};

    for (int p = 0; p < 10; p++) sel_m[p] = 3'd0;

    pReset = 1'b1; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0;
    cfg_wdata = 3'd0; cfg_commit = 1'b0;
    chany_bottom_in = 9'h000; chany_top_in = 9'h000;
    tick(); tick();
    pReset = 1'b0;

    chk("rst_ready", cfg_ready, 1);
    chk("rst_av", active_valid, 0);
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_rdata", cfg_rdata, 0);

    for (int i = 0; i < 4; i++) begin
      chany_bottom_in = pt[i].bot;
      chany_top_in    = pt[i].top;
      #1;
      chk("pt_top_out", chany_top_out, pt[i].exp_top_out);
      chk("pt_bot_out", chany_bottom_out, pt[i].exp_bot_out);
      chk("pt_ipin_zero", ipin_out, 0);
    end
    chany_bottom_in = 9'h155; chany_top_in = 9'h0AA;

    for (int i = 0; i < 11; i++) begin
      cfg_valid = 1'b1; cfg_we = cv[i].we; cfg_addr = cv[i].addr; cfg_wdata = cv[i].wdata;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("cfg%0d_rvalid", i), cfg_rvalid, cv[i].exp_rv);
      chk($sformatf("cfg%0d_rdata", i), cfg_rdata, cv[i].exp_rd);
      chk($sformatf("cfg%0d_err", i), cfg_err, cv[i].exp_err);
      tick();
      chk($sformatf("cfg%0d_rvalid_drop", i), cfg_rvalid, 0);
      chk($sformatf("cfg%0d_err_drop", i), cfg_err, 0);
      chk($sformatf("cfg%0d_rdata_hold", i), cfg_rdata, cv[i].exp_rd);
    end
    sel_m[2] = 3'd3;
    sel_m[5] = 3'd5;
    chk("precommit_ipin", ipin_out, 0);
    chk("precommit_av", active_valid, 0);

    // Commit: ready low two cycles, done on the second, pins live after edge n+1.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("c1_ready", cfg_ready, 0);
    chk("c1_done", cfg_done, 0);
    chk("c1_av", active_valid, 0);
    chk("c1_ipin", ipin_out, 0);
    tick();
    chk("c2_ready", cfg_ready, 0);
    chk("c2_done", cfg_done, 1);
    chk("c2_av", active_valid, 1);
    chk("c2_ipin", ipin_out, model_ipin());
    chk("c2_ipin2", ipin_out[2], chany_top_in[6]);
    chany_top_in = chany_top_in ^ 9'h040;
    #1;
    chk("c2_ipin2_toggle", ipin_out[2], chany_top_in[6]);
    chk("c2_ipin_toggle", ipin_out, model_ipin());
    tick();
    chk("c3_ready", cfg_ready, 1);
    chk("c3_done", cfg_done, 0);

    // Same-cycle write pin 9 sel 5 with commit; commit held into COMMIT must be ignored.
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 3'd5; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("s1_ready", cfg_ready, 0);
    chk("s1_done", cfg_done, 0);
    tick();
    cfg_commit = 1'b0;
    sel_m[9] = 3'd5;
    chk("s2_done", cfg_done, 1);
    chk("s2_ipin", ipin_out, model_ipin());
    chk("s2_ipin9", ipin_out[9], chany_top_in[8]);
    chany_bottom_in = 9'h0F3; chany_top_in = 9'h10C;
    #1;
    chk("s2_ipin_pat", ipin_out, model_ipin());
    chk("s2_ipin9_pat", ipin_out[9], 1);
    tick();
    chk("s3_done", cfg_done, 0);
    chk("s3_ready", cfg_ready, 1);
    tick();
    chk("s4_no_extra_done", cfg_done, 0);
    chk("s4_ready", cfg_ready, 1);

    // Reset landing in COMMIT, with a write presented during the reset cycle.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("r0_ready", cfg_ready, 0);
    pReset = 1'b1; cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 3'd1;
    tick();
    pReset = 1'b0; cfg_valid = 1'b0;
    chk("r1_av", active_valid, 0);
    chk("r1_ipin", ipin_out, 0);
    chk("r1_ready", cfg_ready, 1);
    chk("r1_done", cfg_done, 0);
    chk("r1_rdata", cfg_rdata, 0);
    chk("r1_rvalid", cfg_rvalid, 0);
    tick();
    chk("r2_done", cfg_done, 0);
    chk("r2_av", active_valid, 0);
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = (i == 0) ? 4'd2 : 4'd3;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("r_read%0d_rvalid", i), cfg_rvalid, 1);
      chk($sformatf("r_read%0d_rdata", i), cfg_rdata, 0);
      chk($sformatf("r_read%0d_err", i), cfg_err, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
